// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single main-memory port between the icache refill path
//   (read-only) and the dcache refill/writeback path (read or write).
//   One transaction is outstanding at a time. Requesters are picked
//   round-robin. Multi-beat write data is forwarded to memory, and
//   multi-beat read responses are routed back to the granted requester.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no transaction; grant is registered when any request is valid
//   REQ   | request presented to memory, waiting for mem_req_ready
//   WDATA | forwarding BEATS dcache write beats to memory
//   RRESP | routing BEATS read response beats to the granted client
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   ic_req_*                icache read request (valid/ready/addr)
//   ic_resp_*               icache response beats
//   dc_req_*                dcache request (valid/ready/rw/addr)
//   dc_wdata*, dc_wmask     dcache write beats (valid/ready/data/mask)
//   dc_resp_*               dcache response beats
//   mem_req_*               memory request and write-beat channel
//   mem_resp_*              memory read response beats (no backpressure)
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,

  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic                dc_wdata_valid,
  output logic                dc_wdata_ready,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wmask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RRESP} state_t;

  // grant / last_grant encoding: 0 = icache, 1 = dcache
  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    last_grant_nxt     = last_grant;
    cnt_nxt            = cnt;

    ic_req_ready       = 1'b0;
    ic_resp_valid      = 1'b0;
    ic_resp_data       = '0;
    dc_req_ready       = 1'b0;
    dc_wdata_ready     = 1'b0;
    dc_resp_valid      = 1'b0;
    dc_resp_data       = '0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    unique case (state)
      IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          // On a tie the client that did not win last time gets the port.
          if (ic_req_valid && dc_req_valid) grant_nxt = ~last_grant;
          else                              grant_nxt = dc_req_valid;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end

      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = grant ? dc_req_addr : ic_req_addr;
        mem_req_rw    = grant & dc_req_rw;
        ic_req_ready  = ~grant & mem_req_ready;
        dc_req_ready  =  grant & mem_req_ready;
        if (mem_req_ready) begin
          last_grant_nxt = grant;
          cnt_nxt        = '0;
          state_nxt      = (grant & dc_req_rw) ? WDATA : RRESP;
        end
      end

      WDATA: begin
        mem_req_data_valid = dc_wdata_valid;
        dc_wdata_ready     = mem_req_data_ready;
        mem_req_data_bits  = dc_wdata;
        mem_req_data_mask  = dc_wmask;
        if (dc_wdata_valid && mem_req_data_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      RRESP: begin
        if (mem_resp_valid) begin
          ic_resp_valid = ~grant;
          dc_resp_valid =  grant;
          if (grant) dc_resp_data = mem_resp_data;
          else       ic_resp_data = mem_resp_data;
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter. Inputs change and
//   outputs are sampled shortly after each rising clock edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0]   ic_req_addr;
  logic                ic_resp_valid;
  logic [DATA_W-1:0]   ic_resp_data;
  logic                dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0]   dc_req_addr;
  logic                dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0]   dc_wdata;
  logic [DATA_W/8-1:0] dc_wmask;
  logic                dc_resp_valid;
  logic [DATA_W-1:0]   dc_resp_data;
  logic                mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_data_valid, mem_req_data_ready;
  logic [DATA_W-1:0]   mem_req_data_bits;
  logic [DATA_W/8-1:0] mem_req_data_mask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_wdata_valid = 0; dc_wdata = '0; dc_wmask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  function automatic logic [6:0] ctrl_outs();
    return {mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid,
            dc_resp_valid, mem_req_data_valid, dc_wdata_ready};
  endfunction

  // Called in the first RRESP cycle; returns in the IDLE cycle after it.
  task automatic read_beats(input bit to_dc, input logic [127:0] base, input string tag);
    for (int b = 0; b < BEATS; b++) begin
      mem_resp_valid = 1;
      mem_resp_data  = base + 128'(b);
      #1;
      chk({tag, "_rv"}, {ic_resp_valid, dc_resp_valid}, to_dc ? 2'b01 : 2'b10);
      chk({tag, "_rd"}, to_dc ? dc_resp_data : ic_resp_data, base + 128'(b));
      step();
    end
    mem_resp_valid = 1;
    mem_resp_data  = 128'hdead;
    #1;
    chk({tag, "_end"}, {ic_resp_valid, dc_resp_valid, mem_req_valid}, 3'b000);
    mem_resp_valid = 0;
  endtask

  bit                wv [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
  bit                mr [8] = '{0, 0, 1, 1, 1, 1, 0, 1};
  bit                w;
  int                beat;
  int                hs;
  logic [ADDR_W-1:0] exp_addr;

  initial begin
    do_reset();
    #1;
    chk("rst_ctrl", ctrl_outs(), 7'h00);
    chk("rst_addr", mem_req_addr, '0);

    // stray response beat while idle
    mem_resp_valid = 1; mem_resp_data = 128'h5a5a;
    #1;
    chk("stray_idle", {ic_resp_valid, dc_resp_valid}, 2'b00);
    step();
    chk("stray_idle2", {ic_resp_valid, dc_resp_valid, mem_req_valid}, 3'b000);
    mem_resp_valid = 0;

    // icache-only read
    ic_req_valid = 1; ic_req_addr = 28'h100; mem_req_ready = 1;
    #1;
    chk("ic_idle_norq", {mem_req_valid, ic_req_ready}, 2'b00);
    step();
    chk("ic_req", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}, 4'b1010);
    chk("ic_addr", mem_req_addr, 28'h100);
    step();
    ic_req_valid = 0;
    read_beats(1'b0, 128'hA0, "ic_rd");

    // tie from reset: DC, IC, DC, IC
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h11;
    dc_req_valid = 1; dc_req_addr = 28'h22; dc_req_rw = 0;
    mem_req_ready = 1;
    for (int t = 0; t < 4; t++) begin
      w = (t % 2 == 0);
      exp_addr = w ? 28'h22 : 28'h11;
      #1;
      chk("tie_idle_rdy", {ic_req_ready, dc_req_ready}, 2'b00);
      if (t == 3) begin
        step();
      end else begin
        step();
      end
      chk("tie_req", {mem_req_valid, ic_req_ready, dc_req_ready}, {1'b1, ~w, w});
      chk("tie_addr", mem_req_addr, exp_addr);
      step();
      if (t == 3) begin
        ic_req_valid = 0;
        dc_req_valid = 0;
      end
      read_beats(w, 128'h1000 * (t + 1), "tie_rd");
    end

    // dcache write with sparse data valid and memory stalls
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h2A;
    step();
    chk("wr_req", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}, 4'b1101);
    chk("wr_addr", mem_req_addr, 28'h2A);
    step();
    dc_req_valid = 0; dc_req_rw = 0;
    beat = 0;
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      dc_wdata_valid     = wv[c];
      mem_req_data_ready = mr[c];
      dc_wdata           = 128'hC0DE_0000 + 128'(beat);
      dc_wmask           = 16'(16'h00FF << beat);
      mem_resp_valid     = 1;
      mem_resp_data      = 128'hbad;
      #1;
      chk("wr_dv", {mem_req_data_valid, dc_wdata_ready}, {wv[c], mr[c]});
      chk("wr_bits", mem_req_data_bits, 128'hC0DE_0000 + 128'(beat));
      chk("wr_mask", mem_req_data_mask, 16'(16'h00FF << beat));
      chk("wr_noresp", {ic_resp_valid, dc_resp_valid}, 2'b00);
      if (mem_req_data_valid && mem_req_data_ready) hs++;
      if (wv[c] && mr[c]) beat++;
      step();
    end
    mem_resp_valid = 0;
    dc_wdata_valid = 1; mem_req_data_ready = 1;
    #1;
    chk("wr_idle", {mem_req_data_valid, dc_wdata_ready, mem_req_valid}, 3'b000);
    chk("wr_beats", hs, BEATS);
    dc_wdata_valid = 0; mem_req_data_ready = 0;

    // memory stalls the request for 5 cycles
    mem_req_ready = 0;
    ic_req_valid = 1; ic_req_addr = 28'h155;
    step();
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", {mem_req_valid, ic_req_ready, dc_req_ready}, 3'b100);
      chk("stall_addr", mem_req_addr, 28'h155);
      step();
    end
    mem_req_ready = 1;
    #1;
    chk("stall_rdy", {mem_req_valid, ic_req_ready, dc_req_ready}, 3'b110);
    step();
    ic_req_valid = 0;

    // reset after 2 of 4 beats
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hE0 + 128'(b);
      #1;
      chk("mid_rv", {ic_resp_valid, dc_resp_valid}, 2'b10);
      chk("mid_rd", ic_resp_data, 128'hE0 + 128'(b));
      step();
    end
    mem_resp_valid = 0;
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_ctrl", ctrl_outs(), 7'h00);
    chk("mid_rst_data", ic_resp_data, '0);
    for (int b = 2; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hE0 + 128'(b);
      #1;
      chk("mid_drop", {ic_resp_valid, dc_resp_valid, mem_req_valid}, 3'b000);
      step();
    end
    mem_resp_valid = 0;

    // normal read after the abandoned one
    ic_req_valid = 1; ic_req_addr = 28'h300; mem_req_ready = 1;
    step();
    chk("post_req", {mem_req_valid, ic_req_ready}, 2'b11);
    chk("post_addr", mem_req_addr, 28'h300);
    step();
    ic_req_valid = 0;
    read_beats(1'b0, 128'hF00, "post_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
Single-outstanding arbiter that shares one main-memory port between the icache refill path (read-only) and the dcache refill/writeback path (read or write). Sits between the two caches serving the pipeline's icache/dcache ports and main memory. Selects requesters round-robin, forwards the request and any multi-beat write data, and routes multi-beat read responses back to the requester.

Parameters:
ADDR_W, 28, memory request address width (line-granular)
DATA_W, 128, memory data beat width
BEATS, 4, data beats per read response and per write request

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ic_req_valid  in  1  icache read request
ic_req_ready  out  1  icache request accepted
ic_req_addr  in  ADDR_W  icache read address
ic_resp_valid  out  1  icache response beat valid
ic_resp_data  out  DATA_W  icache response beat
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted
dc_req_rw  in  1  1=write, 0=read
dc_req_addr  in  ADDR_W  dcache address
dc_wdata_valid  in  1  dcache write beat valid
dc_wdata_ready  out  1  dcache write beat accepted
dc_wdata  in  DATA_W  dcache write beat
dc_wmask  in  DATA_W/8  byte mask for write beat
dc_resp_valid  out  1  dcache response beat valid
dc_resp_data  out  DATA_W  dcache response beat
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1=write
mem_req_addr  out  ADDR_W  memory address
mem_req_data_valid  out  1  write beat valid
mem_req_data_ready  in  1  memory accepts write beat
mem_req_data_bits  out  DATA_W  write beat
mem_req_data_mask  out  DATA_W/8  write byte mask
mem_resp_valid  in  1  read response beat valid
mem_resp_data  in  DATA_W  read response beat

Behaviour:
- Reset (synchronous, has priority over everything): state=IDLE, beat counter=0, last_grant=IC; all valid/ready outputs 0; data outputs are don't-care, driven to 0. A reset issued mid-transaction abandons it; response beats arriving afterwards are dropped.
- States: IDLE, REQ, WDATA, RRESP. Exactly one transaction is outstanding at a time.
- IDLE: if any req_valid is high, register the grant and go to REQ next cycle (1-cycle arbitration latency). If only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins, so after reset DC wins a tie. No ready is asserted in IDLE.
- REQ: mem_req_valid=1, with addr and rw muxed from the granted client (rw=0 for IC). The granted client's req_ready equals mem_req_ready combinationally; the other client's ready is 0. On handshake: update last_grant, then go to WDATA if write, else RRESP. The client holds valid/addr/rw stable until ready.
- WDATA: mem_req_data_valid=dc_wdata_valid; dc_wdata_ready=mem_req_data_ready; bits and mask pass through. The counter increments on each data handshake. On the BEATS-th handshake, go to IDLE with counter=0. Writes produce no response.
- RRESP: each mem_resp_valid drives the granted client's resp_valid=1 with resp_data=mem_resp_data, with no added latency and no backpressure. The counter increments per beat; on beat BEATS go to IDLE.
- mem_resp_valid outside RRESP is ignored; no client sees it.
- A new request may be granted in the IDLE cycle that follows the last beat, so the minimum gap between transactions is 1 cycle.
- Counter width is clog2(BEATS)+1, and it must not wrap during a transaction.

Test Plan:
- IC only read @0x100, mem_req_ready=1, 4 resp beats A..D -> mem_req_valid in cycle after ic_req_valid; ic_resp_valid high 4 cycles with A..D; dc_resp_valid stays 0; returns to IDLE.
- IC and DC both valid from reset -> DC granted first, then IC; repeat with both held -> grants alternate DC,IC,DC,IC.
- DC write @0x2A, 4 beats with dc_wdata_valid toggling and mem_req_data_ready stalling 2 cycles -> exactly 4 beats pass through with matching data/mask, no resp pulses, returns to IDLE.
- mem_req_ready held 0 for 5 cycles in REQ -> mem_req_valid/addr stay stable; ic/dc_req_ready 0 until ready rises.
- Stray mem_resp_valid in IDLE -> no ic/dc_resp_valid asserted.
- Reset asserted after 2 of 4 read beats -> next cycle state IDLE, outputs 0; remaining 2 beats dropped; a following request completes normally with 4 beats.
